// File: rtl/hdmi_acr_pkg.sv
// rtl/hdmi_acr_pkg.sv - shared types and constants for audio clock regeneration
package hdmi_acr_pkg;

  localparam logic [7:0] ACR_HB0 = 8'h01;

  typedef logic [19:0] n_t;
  typedef logic [19:0] cts_t;

  typedef enum logic [1:0] {IDLE, ACQUIRE, RUN} acr_state_t;

  function automatic logic [20:0] abs_diff(input cts_t a, input cts_t b);
    return (a > b) ? {1'b0, a - b} : {1'b0, b - a};
  endfunction

endpackage

// File: rtl/acr_phase_accumulator.sv
// rtl/acr_phase_accumulator.sv - N/CTS phase accumulator producing the 128fs enable
module acr_phase_accumulator
  import hdmi_acr_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  n_t   n,
  input  cts_t cts,
  input  logic run,
  input  logic clear,
  output logic fire,
  output logic pulse
);

  logic [20:0] acc;
  logic [20:0] sum;

  // acc can sit above a freshly lowered CTS; it drains by one subtraction per cycle
  always_comb begin
    sum  = acc + {1'b0, n};
    fire = run && (sum >= {1'b0, cts});
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= fire;
      if (run) begin
        acc <= fire ? (sum - {1'b0, cts}) : sum;
      end
    end
  end

endmodule

// File: rtl/audio_clock_regeneration_receiver.sv
// rtl/audio_clock_regeneration_receiver.sv - ACR packet decode, lock FSM and audio clock enables
module audio_clock_regeneration_receiver
  import hdmi_acr_pkg::*;
#(
  parameter int CTS_TOLERANCE  = 2,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             packet_valid,
  input  logic [23:0]      header,
  input  logic [3:0][55:0] sub,
  output logic [19:0]      n_value,
  output logic [19:0]      cts_value,
  output logic             locked,
  output logic             clk_audio_128_en,
  output logic             sample_en
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  acr_state_t    state;
  n_t            pkt_n;
  cts_t          pkt_cts;
  logic          accept;
  logic          same_params;
  logic          timeout_hit;
  logic          stay_run;
  logic          enter_run;
  logic          fire;
  logic [TW-1:0] idle_cnt;
  logic [TW-1:0] idle_cnt_inc;
  logic [6:0]    div;
  logic          unused_sub;

  // subpackets 1..3 repeat subpacket 0, and the upper nibbles of SB1/SB4 are reserved
  assign unused_sub = ^{sub[3:1], sub[0][7:0], sub[0][15:12], sub[0][39:36]};

  always_comb begin
    pkt_cts      = {sub[0][11:8], sub[0][23:16], sub[0][31:24]};
    pkt_n        = {sub[0][35:32], sub[0][47:40], sub[0][55:48]};
    accept       = packet_valid && (header == {16'h0000, ACR_HB0}) &&
                   (pkt_n != '0) && (pkt_cts != '0) && (pkt_n < pkt_cts);
    same_params  = (pkt_n == n_value) &&
                   (abs_diff(pkt_cts, cts_value) <= 21'(CTS_TOLERANCE));
    idle_cnt_inc = idle_cnt + TW'(1);
    timeout_hit  = !accept && (idle_cnt_inc == TW'(TIMEOUT_CYCLES));
    // pulses only on cycles that stay in RUN, so no enable escapes a lock drop
    stay_run     = (state == RUN) && !timeout_hit && !(accept && !same_params);
    enter_run    = (state == ACQUIRE) && accept && same_params;
  end

  acr_phase_accumulator u_acc (
    .clk   (clk_pixel),
    .reset (reset),
    .n     (n_value),
    .cts   (cts_value),
    .run   (stay_run),
    .clear (enter_run),
    .fire  (fire),
    .pulse (clk_audio_128_en)
  );

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state     <= IDLE;
      n_value   <= '0;
      cts_value <= '0;
      locked    <= 1'b0;
      sample_en <= 1'b0;
      idle_cnt  <= '0;
      div       <= '0;
    end else begin
      sample_en <= fire && (div == 7'd127);
      if (enter_run) begin
        div <= '0;
      end else if (fire) begin
        div <= div + 7'd1;
      end

      if (accept) begin
        n_value   <= pkt_n;
        cts_value <= pkt_cts;
        idle_cnt  <= '0;
      end else if (timeout_hit) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt_inc;
      end

      locked <= stay_run || enter_run;
      case (state)
        IDLE:    if (accept) state <= ACQUIRE;
        ACQUIRE: if (timeout_hit) state <= IDLE;
                 else if (enter_run) state <= RUN;
        RUN:     if (timeout_hit) state <= IDLE;
                 else if (accept && !same_params) state <= ACQUIRE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_clock_regeneration_receiver.sv
// tb/tb_audio_clock_regeneration_receiver.sv - randomized model-checked bench for the ACR receiver
module tb_audio_clock_regeneration_receiver;

  localparam int TIMEOUT = 1000;
  localparam int TOL     = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             packet_valid;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic [19:0]      n_value;
  logic [19:0]      cts_value;
  logic             locked;
  logic             clk_audio_128_en;
  logic             sample_en;

  int tests = 0;
  int fails = 0;
  int dut_pulses = 0;
  int dut_samples = 0;

  audio_clock_regeneration_receiver #(
    .CTS_TOLERANCE  (TOL),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk_pixel        (clk),
    .reset            (reset),
    .packet_valid     (packet_valid),
    .header           (header),
    .sub              (sub),
    .n_value          (n_value),
    .cts_value        (cts_value),
    .locked           (locked),
    .clk_audio_128_en (clk_audio_128_en),
    .sample_en        (sample_en)
  );

  always #5 clk = ~clk;

  // reference model state: 0 idle, 1 acquire, 2 run
  int m_state, m_n, m_cts, m_idle, m_since_lock;
  longint m_acc;
  bit m_pulse, m_sample;

  function automatic logic [55:0] enc(input int n, input int cts);
    logic [19:0] nn;
    logic [19:0] cc;
    logic [7:0]  junk;
    nn   = n[19:0];
    cc   = cts[19:0];
    junk = 8'($urandom);
    return {nn[7:0], nn[15:8], junk[7:4], nn[19:16],
            cc[7:0], cc[15:8], junk[3:0], cc[19:16], junk};
  endfunction

  task automatic model_step(input bit rst, input bit vld, input logic [23:0] hdr,
                            input logic [55:0] s);
    int pn, pc, diff, ns;
    bit ok, same, tmo;
    longint sum;
    if (rst) begin
      m_state = 0; m_n = 0; m_cts = 0; m_idle = 0; m_acc = 0;
      m_since_lock = 0; m_pulse = 0; m_sample = 0;
      return;
    end
    pc   = (int'(s[11:8]) << 16) + (int'(s[23:16]) << 8) + int'(s[31:24]);
    pn   = (int'(s[35:32]) << 16) + (int'(s[47:40]) << 8) + int'(s[55:48]);
    ok   = vld && hdr == 24'h000001 && pn != 0 && pc != 0 && pn < pc;
    diff = (pc > m_cts) ? pc - m_cts : m_cts - pc;
    same = ok && pn == m_n && diff <= TOL;
    tmo  = !ok && (m_idle + 1 == TIMEOUT);
    if (tmo) ns = 0;
    else if (!ok) ns = m_state;
    else if (m_state == 0) ns = 1;
    else ns = same ? 2 : 1;
    m_pulse = 0;
    m_sample = 0;
    if (m_state == 2 && ns == 2) begin
      sum = m_acc + m_n;
      if (sum >= m_cts) begin
        m_acc = sum - m_cts;
        m_pulse = 1;
        m_since_lock++;
        m_sample = (m_since_lock % 128 == 0);
      end else begin
        m_acc = sum;
      end
    end
    if (m_state == 1 && ns == 2) begin
      m_acc = 0;
      m_since_lock = 0;
    end
    if (ok) begin
      m_n = pn; m_cts = pc; m_idle = 0;
    end else if (tmo) m_idle = 0;
    else m_idle++;
    m_state = ns;
  endtask

  initial begin
    bit c_rst, c_vld;
    logic [23:0] c_hdr;
    logic [55:0] c_sub;
    forever begin
      @(posedge clk);
      c_rst = reset; c_vld = packet_valid; c_hdr = header; c_sub = sub[0];
      @(negedge clk);
      model_step(c_rst, c_vld, c_hdr, c_sub);
      tests++;
      if ({n_value, cts_value, locked, clk_audio_128_en, sample_en} !==
          {m_n[19:0], m_cts[19:0], m_state == 2, m_pulse, m_sample}) begin
        fails++;
        $display("FAIL cycle t=%0t: dut n=%0d cts=%0d lock=%b en=%b smp=%b, model n=%0d cts=%0d lock=%b en=%b smp=%b",
                 $time, n_value, cts_value, locked, clk_audio_128_en, sample_en,
                 m_n, m_cts, m_state == 2, m_pulse, m_sample);
      end
      if (clk_audio_128_en === 1'b1) dut_pulses++;
      if (sample_en === 1'b1) dut_samples++;
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic [23:0] hdr, input logic [55:0] s0);
    packet_valid = 1'b1;
    header = hdr;
    sub = {56'($urandom), 56'($urandom), 56'($urandom), s0};
    tick();
    packet_valid = 1'b0;
  endtask

  task automatic send(input int n, input int cts);
    send_raw(24'h000001, enc(n, cts));
  endtask

  // L cycles with same-parameter refresh packets so the timeout never fires
  task automatic run_counted(input int len, input int n, input int cts,
                             output int pulses, output int samples);
    int p0, s0;
    p0 = dut_pulses;
    s0 = dut_samples;
    for (int i = 0; i < len; i++) begin
      if (i % 500 == 499) send(n, cts);
      else tick();
    end
    @(negedge clk);
    #1;
    pulses = dut_pulses - p0;
    samples = dut_samples - s0;
  endtask

  initial begin
    int p, s, bn, bc, j;
    reset = 1'b1;
    packet_valid = 1'b0;
    header = '0;
    sub = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_outputs", {n_value, cts_value, locked, clk_audio_128_en, sample_en}, 0);

    send(6144, 25200);
    check("acq_locked", locked, 0);
    check("acq_n", n_value, 6144);
    check("acq_cts", cts_value, 25200);
    send(6144, 25200);
    check("lock_after_second", locked, 1);
    run_counted(25200, 6144, 25200, p, s);
    check("pulses_48k", p, 6144);
    check("samples_48k", s, 48);

    send_raw(24'h000002, enc(6144, 25000));
    check("bad_hb0_n", n_value, 6144);
    check("bad_hb0_lock", locked, 1);
    send(0, 25200);
    check("n_zero_n", n_value, 6144);
    send(30000, 25200);
    check("n_ge_cts_n", n_value, 6144);
    check("n_ge_cts_cts", cts_value, 25200);
    check("n_ge_cts_lock", locked, 1);

    send(6144, 25202);
    check("tol2_lock", locked, 1);
    check("tol2_cts", cts_value, 25202);
    send(6144, 25210);
    check("tol8_lock", locked, 0);
    run_counted(50, 6144, 25210, p, s);
    check("tol8_no_pulses", p, 0);

    send(6144, 25210);
    check("relock_a", locked, 1);
    send(6272, 28000);
    check("new_n_unlock", locked, 0);
    send(6272, 28000);
    check("new_n_relock", locked, 1);
    run_counted(28000, 6272, 28000, p, s);
    check("pulses_44k1", p, 6272);
    check("samples_44k1", s, 49);

    send(6272, 28000);
    repeat (TIMEOUT - 1) tick();
    check("pre_timeout_lock", locked, 1);
    tick();
    check("timeout_lock", locked, 0);
    run_counted(200, 0, 0, p, s);
    check("timeout_no_pulses", p, 0);

    send(6144, 25200);
    send(6144, 25200);
    repeat (300) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset_outputs", {n_value, cts_value, locked, clk_audio_128_en, sample_en}, 0);
    send(6144, 25200);
    check("post_reset_first", locked, 0);
    send(6144, 25200);
    check("post_reset_second", locked, 1);

    bn = 10;
    bc = 37;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 1499) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 9))
          0: begin
            bn = int'($urandom_range(1, 40));
            bc = bn + int'($urandom_range(1, 200));
            send(bn, bc);
          end
          1: send_raw(24'h000101, enc(bn, bc));
          2: send(bc, bn);
          3: send(0, bc);
          default: begin
            j = int'($urandom_range(0, 10)) - 5;
            send(bn, (bc + j < 1) ? 1 : bc + j);
          end
        endcase
      end else begin
        tick();
      end
    end
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/audio_clock_regeneration_receiver.md
# audio_clock_regeneration_receiver

Sink-side counterpart of the Audio Clock Regeneration (ACR) packet path. Accepts decoded HDMI data-island packets in the pixel clock domain and extracts N and CTS from ACR packets (HB0 = 0x01). It then regenerates the 128·fs audio clock as a clock-enable, using a phase accumulator: f_128fs = f_pixel · N / CTS. It sits after the packet decoder in a receive/loopback path and feeds audio sample de-packing and the I2S/DAC output logic.

## Interface
- CTS_TOLERANCE, default 2: maximum |CTS − CTS_prev| between consecutive packets that still counts as stable.
- TIMEOUT_CYCLES, default 2_000_000: clk_pixel cycles without an accepted ACR packet before lock is dropped.
- clk_pixel  input  1  TMDS character (pixel) clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- packet_valid  input  1  one-cycle strobe: header/sub hold a complete decoded packet.
- header  input  24  header[7:0]=HB0, [15:8]=HB1, [23:16]=HB2.
- sub  input  4×56  subpacket bytes; sub[k][8j+7:8j] = SBj of subpacket k.
- n_value  output  20  last accepted N.
- cts_value  output  20  last accepted CTS.
- locked  output  1  regeneration running with stable parameters.
- clk_audio_128_en  output  1  one-cycle pulse at mean rate 128·fs.
- sample_en  output  1  one-cycle pulse on every 128th clk_audio_128_en (rate fs).

## Operation
- Packet acceptance requires packet_valid, HB0 = 0x01, HB1 = 0, HB2 = 0.
- Field decode from sub[0]: CTS = {SB1[3:0], SB2, SB3}; N = {SB4[3:0], SB5, SB6}. Subpackets 1–3 are ignored (they are copies).
- Packets with N = 0, CTS = 0, or N ≥ CTS are rejected: no state change and the timeout is not reset.
- States:
  - IDLE: reset state; no pulses. An accepted packet stores N/CTS and moves to ACQUIRE.
  - ACQUIRE: no pulses. An accepted packet with identical N and |ΔCTS| ≤ CTS_TOLERANCE moves to RUN; clear acc and div. Any other accepted packet stores its N/CTS and stays in ACQUIRE.
  - RUN: pulses generated.
    - An accepted packet with identical N updates CTS; acc is kept so phase stays continuous.
    - A packet with different N, or |ΔCTS| > CTS_TOLERANCE, stores the new values and moves to ACQUIRE.
  - Timeout: the counter reaching TIMEOUT_CYCLES in any state returns to IDLE.
- Accumulator (RUN only, 21-bit unsigned): each cycle, sum = acc + N.
  - If sum ≥ CTS: acc ← sum − CTS and pulse clk_audio_128_en.
  - Otherwise: acc ← sum.
  - At most one pulse per cycle; after a CTS decrease, acc may transiently exceed CTS and converges by one subtraction per cycle.
- Divider: 7-bit counter div increments on each clk_audio_128_en. sample_en pulses with the clk_audio_128_en that wraps div from 127 to 0.
- Comparisons are unsigned 21-bit; ΔCTS is an absolute difference.

## Timing
- Reset values: n_value = 0, cts_value = 0, locked = 0, clk_audio_128_en = 0, sample_en = 0, acc = 0, div = 0, timeout counter = 0, state IDLE.
- An accepted packet at cycle t updates n_value/cts_value at t+1. The locked transition also appears at t+1.
- In RUN, the first pulse can occur at the earliest at t+2 after the locking packet.
- Outputs are registered; no combinational input-to-output paths.
- A packet accepted in the same cycle the timeout expires takes priority: the timeout counter clears and the state does not drop.
- Reset mid-operation returns everything to reset values in the next cycle. A pulse asserted in the reset cycle is allowed; none follow.
- locked = 1 exactly in RUN.

## Structure
- Shared package hdmi_acr_pkg:
  - ACR header constant (8'h01).
  - 20-bit N/CTS typedefs.
  - State enum {IDLE, ACQUIRE, RUN}.
- Sub-module acr_phase_accumulator: holds N/CTS inputs, run enable, acc, and the pulse output. The top level holds decode, the state machine, the timeout counter, and the divider.

## Test plan
- Two ACR packets with N = 6144, CTS = 25200, then run 25200·48 cycles: exactly 6144·48 clk_audio_128_en pulses and 2304 sample_en pulses; locked rises 1 cycle after the second packet.
- Packet with HB0 = 0x02, or with N = 0, or with N = 30000 and CTS = 25200: n_value/cts_value unchanged and state unchanged.
- In RUN, a packet with CTS = 25202 (Δ = 2): stays locked with no phase reset. A following packet with CTS = 25210 (Δ = 8): locked drops next cycle and pulses stop.
- In RUN, a packet with N = 6272 (44.1 kHz): locked drops and a second identical packet relocks. Over 28000 cycles with CTS = 28000, exactly 6272 pulses.
- No packets for TIMEOUT_CYCLES (set to 1000 in the bench): locked drops at cycle 1000, state IDLE, no further pulses.
- Assert reset mid-RUN for 1 cycle: all outputs 0 next cycle; two fresh packets are required to relock.
